// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch target, zero flag and destination select.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit with HI/LO and stall logic.
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_hold,
    input  logic [31:0] i_PCNext,
    input  logic [31:0] i_RSData,
    input  logic [31:0] i_RTData,
    input  logic [4:0]  i_RSAddr,
    input  logic [4:0]  i_RTAddr,
    input  logic [4:0]  i_RDAddr,
    input  logic [31:0] i_ExtImm,
    input  logic [4:0]  i_Shamt,
    input  logic [5:0]  i_Funct,
    input  logic [3:0]  i_ALUOp,
    input  logic        i_ALUSrc,
    input  logic        i_RegDst,
    input  logic        i_MEM_RegWrite,
    input  logic [4:0]  i_MEM_WAddr,
    input  logic [31:0] i_MEM_Result,
    input  logic        i_WB_RegWrite,
    input  logic [4:0]  i_WB_WAddr,
    input  logic [31:0] i_WB_Data,
    output logic [31:0] o_ALUResult,
    output logic [31:0] o_StoreData,
    output logic [4:0]  o_WAddr,
    output logic [31:0] o_BranchTarget,
    output logic        o_Zero,
    output logic        o_stall_req,
    output logic [1:0]  dbg_md_state
);
    localparam int CNT_W = $clog2(MD_CYCLES);

    logic [31:0] fwd_rs, fwd_rt, op_a, op_b;
    logic [31:0] hi_q, lo_q;
    logic [31:0] rtype_res;
    logic        is_rtype;

    // The younger producer (MEM) wins over WB; register 0 is never forwarded.
    always_comb begin
        fwd_rs = i_RSData;
        if (i_MEM_RegWrite && (i_MEM_WAddr != 5'd0) && (i_MEM_WAddr == i_RSAddr))
            fwd_rs = i_MEM_Result;
        else if (i_WB_RegWrite && (i_WB_WAddr != 5'd0) && (i_WB_WAddr == i_RSAddr))
            fwd_rs = i_WB_Data;
    end

    always_comb begin
        fwd_rt = i_RTData;
        if (i_MEM_RegWrite && (i_MEM_WAddr != 5'd0) && (i_MEM_WAddr == i_RTAddr))
            fwd_rt = i_MEM_Result;
        else if (i_WB_RegWrite && (i_WB_WAddr != 5'd0) && (i_WB_WAddr == i_RTAddr))
            fwd_rt = i_WB_Data;
    end

    assign op_a           = fwd_rs;
    assign op_b           = i_ALUSrc ? i_ExtImm : fwd_rt;
    assign o_StoreData    = fwd_rt;
    assign o_WAddr        = i_RegDst ? i_RDAddr : i_RTAddr;
    assign o_BranchTarget = i_PCNext + (i_ExtImm << 2);
    assign o_Zero         = (op_a - op_b) == 32'd0;
    assign is_rtype       = (i_ALUOp == 4'd2);

    always_comb begin
        rtype_res = 32'd0;
        case (i_Funct)
            6'h20, 6'h21: rtype_res = op_a + op_b;
            6'h22, 6'h23: rtype_res = op_a - op_b;
            6'h24:        rtype_res = op_a & op_b;
            6'h25:        rtype_res = op_a | op_b;
            6'h26:        rtype_res = op_a ^ op_b;
            6'h27:        rtype_res = ~(op_a | op_b);
            6'h2A:        rtype_res = {31'd0, $signed(op_a) < $signed(op_b)};
            6'h2B:        rtype_res = {31'd0, op_a < op_b};
            6'h00:        rtype_res = op_b << i_Shamt;
            6'h02:        rtype_res = op_b >> i_Shamt;
            6'h03:        rtype_res = $signed(op_b) >>> i_Shamt;
            6'h04:        rtype_res = op_b << op_a[4:0];
            6'h06:        rtype_res = op_b >> op_a[4:0];
            6'h07:        rtype_res = $signed(op_b) >>> op_a[4:0];
            6'h10:        rtype_res = hi_q;
            6'h12:        rtype_res = lo_q;
            default:      rtype_res = 32'd0;
        endcase
    end

    always_comb begin
        case (i_ALUOp)
            4'd1:    o_ALUResult = op_a - op_b;
            4'd2:    o_ALUResult = rtype_res;
            4'd3:    o_ALUResult = op_a & op_b;
            4'd4:    o_ALUResult = op_a | op_b;
            4'd5:    o_ALUResult = op_a ^ op_b;
            4'd6:    o_ALUResult = i_ExtImm << 16;
            4'd7:    o_ALUResult = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd8:    o_ALUResult = {31'd0, op_a < op_b};
            default: o_ALUResult = op_a + op_b;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t        md_state, md_state_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic [63:0]      md_prod, md_prod_nxt;
    logic [31:0]      md_divisor, md_rs;
    logic             md_is_div, md_neg_q, md_neg_r, md_div_zero;
    logic             md_start, md_last, is_muldiv, is_mthi, is_mtlo, op_signed;
    logic [32:0]      mul_sum;
    logic [33:0]      div_diff;
    logic [31:0]      abs_a, abs_b, res_hi, res_lo;

    // Stall contract: o_stall_req high means the instruction in EX is not
    // accepted this cycle; upstream freezes and EX/MEM takes a bubble.
    // i_hold high means the pipeline is frozen elsewhere; the unit parks in
    // DONE until it drops so the same instruction is not started twice.
    assign is_muldiv = is_rtype && (i_Funct[5:2] == 4'b0110);
    assign is_mthi   = is_rtype && (i_Funct == 6'h11);
    assign is_mtlo   = is_rtype && (i_Funct == 6'h13);
    assign md_start  = nrst && (md_state == MD_IDLE) && is_muldiv;
    assign md_last   = (md_cnt == CNT_W'(MD_CYCLES - 1));
    assign op_signed = ~i_Funct[0];
    assign abs_a     = (op_signed && op_a[31]) ? -op_a : op_a;
    assign abs_b     = (op_signed && op_b[31]) ? -op_b : op_b;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) md_state <= MD_IDLE;
        else       md_state <= md_state_nxt;
    end

    always_comb begin
        md_state_nxt = md_state;
        case (md_state)
            MD_IDLE: if (md_start) md_state_nxt = MD_BUSY;
            MD_BUSY: if (md_last)  md_state_nxt = MD_DONE;
            MD_DONE: if (!i_hold)  md_state_nxt = MD_IDLE;
            default:               md_state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        o_stall_req  = md_start || (md_state == MD_BUSY);
        dbg_md_state = md_state;
    end

    // Multiply is shift-add on {acc, multiplier}; divide is restoring on {rem, quotient}.
    always_comb begin
        mul_sum  = {1'b0, md_prod[63:32]} + {1'b0, (md_prod[0] ? md_divisor : 32'd0)};
        div_diff = {1'b0, md_prod[63:31]} - {2'b00, md_divisor};
        if (md_is_div)
            md_prod_nxt = div_diff[33] ? {md_prod[62:0], 1'b0}
                                       : {div_diff[31:0], md_prod[30:0], 1'b1};
        else
            md_prod_nxt = {mul_sum, md_prod[31:1]};
    end

    always_comb begin
        res_hi = md_prod_nxt[63:32];
        res_lo = md_prod_nxt[31:0];
        if (md_div_zero) begin
            res_hi = md_rs;
            res_lo = 32'hFFFF_FFFF;
        end else if (md_is_div) begin
            if (md_neg_q) res_lo = -md_prod_nxt[31:0];
            if (md_neg_r) res_hi = -md_prod_nxt[63:32];
        end else if (md_neg_q) begin
            {res_hi, res_lo} = -md_prod_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            md_cnt      <= '0;
            md_prod     <= 64'd0;
            md_divisor  <= 32'd0;
            md_rs       <= 32'd0;
            md_is_div   <= 1'b0;
            md_neg_q    <= 1'b0;
            md_neg_r    <= 1'b0;
            md_div_zero <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (md_start) begin
                        md_cnt      <= '0;
                        md_prod     <= {32'd0, abs_a};
                        md_divisor  <= abs_b;
                        md_rs       <= op_a;
                        md_is_div   <= i_Funct[1];
                        md_neg_q    <= op_signed && (op_a[31] ^ op_b[31]);
                        md_neg_r    <= op_signed && op_a[31];
                        md_div_zero <= i_Funct[1] && (op_b == 32'd0);
                    end else if (!i_hold) begin
                        if (is_mthi) hi_q <= op_a;
                        if (is_mtlo) lo_q <= op_a;
                    end
                end
                MD_BUSY: begin
                    md_prod <= md_prod_nxt;
                    md_cnt  <= md_cnt + 1'b1;
                    if (md_last) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_md;

    assign hi_q         = 32'd0;
    assign lo_q         = 32'd0;
    assign o_stall_req  = 1'b0;
    assign dbg_md_state = 2'd0;
    assign unused_md    = &{1'b0, clk, nrst, i_hold, is_rtype, CNT_W[0]};
`endif

endmodule
